// File: rtl/cpu_io_hub.sv
// Multi-channel I/O hub: per-channel rx/tx FIFOs bridging the CPU byte port to
// 4-phase receive handshakes and strobed transmit launches.
module cpu_io_hub #(
  parameter  int NCH   = 2,
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int SW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   rx_irr,
  input  logic [NCH*W-1:0] rx_data,
  output logic [NCH-1:0]   rx_ack,
  output logic [NCH-1:0]   tx_req,
  output logic [NCH*W-1:0] tx_data,
  input  logic [NCH-1:0]   tx_busy,
  input  logic [SW-1:0]    cpu_sel,
  input  logic             cpu_rd,
  output logic [W-1:0]     cpu_rdata,
  input  logic             cpu_wr,
  input  logic [W-1:0]     cpu_wdata,
  output logic [NCH-1:0]   rx_avail,
  output logic [NCH-1:0]   tx_full,
  input  logic [NCH-1:0]   irq_en,
  output logic             irq,
  output logic [NCH-1:0]   wr_drop,
  input  logic             clr_drop
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {R_IDLE, R_ACK} rx_st_e;
  typedef enum logic [1:0] {T_IDLE, T_REQ, T_GUARD, T_WAIT} tx_st_e;

  logic [NCH-1:0][W-1:0] rx_head;
  logic [NCH-1:0]        rx_nonempty;
  logic [W-1:0]          cpu_rdata_q, cpu_rdata_d;
  logic                  irq_q;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic          sel;
    logic [W-1:0]  rxm_q [DEPTH];
    logic [AW:0]   rxw_q, rxr_q, rxw_d, rxr_d;
    logic          rx_fl, rx_push, rx_pop;
    rx_st_e        rs_q, rs_d;
    logic [W-1:0]  txm_q [DEPTH];
    logic [AW:0]   txw_q, txr_q, txw_d, txr_d;
    logic          tx_fl, tx_mt, tx_push, tx_pop;
    tx_st_e        ts_q, ts_d;
    logic [W-1:0]  txd_q, txd_d;
    logic          avail_q, full_q, drop_q, drop_d;

    assign sel            = (cpu_sel == SW'(c));
    assign rx_nonempty[c] = (rxw_q != rxr_q);
    assign rx_fl          = (rxw_q[AW] != rxr_q[AW]) && (rxw_q[AW-1:0] == rxr_q[AW-1:0]);
    assign rx_pop         = cpu_rd && sel && rx_nonempty[c];
    assign rx_head[c]     = rxm_q[rxr_q[AW-1:0]];

    always_comb begin
      rs_d    = rs_q;
      rx_push = 1'b0;
      case (rs_q)
        R_IDLE: if (rx_irr[c] && !rx_fl) begin
          rx_push = 1'b1;
          rs_d    = R_ACK;
        end
        R_ACK:   if (!rx_irr[c]) rs_d = R_IDLE;
        default: rs_d = R_IDLE;
      endcase
    end

    assign rxw_d = rxw_q + {{AW{1'b0}}, rx_push};
    assign rxr_d = rxr_q + {{AW{1'b0}}, rx_pop};

    assign tx_mt   = (txw_q == txr_q);
    assign tx_fl   = (txw_q[AW] != txr_q[AW]) && (txw_q[AW-1:0] == txr_q[AW-1:0]);
    assign tx_push = cpu_wr && sel && !tx_fl;

    // tx_busy is deliberately not sampled in T_GUARD: the peripheral raises it a cycle late.
    always_comb begin
      ts_d   = ts_q;
      txd_d  = txd_q;
      tx_pop = 1'b0;
      case (ts_q)
        T_IDLE: if (!tx_mt && !tx_busy[c]) begin
          tx_pop = 1'b1;
          txd_d  = txm_q[txr_q[AW-1:0]];
          ts_d   = T_REQ;
        end
        T_REQ:   ts_d = T_GUARD;
        T_GUARD: ts_d = T_WAIT;
        T_WAIT:  if (!tx_busy[c]) ts_d = T_IDLE;
        default: ts_d = T_IDLE;
      endcase
    end

    assign txw_d = txw_q + {{AW{1'b0}}, tx_push};
    assign txr_d = txr_q + {{AW{1'b0}}, tx_pop};

    // A drop in the same cycle as clr_drop leaves the bit set.
    always_comb begin
      drop_d = drop_q;
      if (clr_drop) drop_d = 1'b0;
      if (cpu_wr && sel && tx_fl) drop_d = 1'b1;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        rs_q    <= R_IDLE;
        ts_q    <= T_IDLE;
        rxw_q   <= '0;
        rxr_q   <= '0;
        txw_q   <= '0;
        txr_q   <= '0;
        txd_q   <= '0;
        avail_q <= 1'b0;
        full_q  <= 1'b0;
        drop_q  <= 1'b0;
      end else begin
        rs_q    <= rs_d;
        ts_q    <= ts_d;
        rxw_q   <= rxw_d;
        rxr_q   <= rxr_d;
        txw_q   <= txw_d;
        txr_q   <= txr_d;
        txd_q   <= txd_d;
        avail_q <= (rxw_d != rxr_d);
        full_q  <= (txw_d[AW] != txr_d[AW]) && (txw_d[AW-1:0] == txr_d[AW-1:0]);
        drop_q  <= drop_d;
      end
    end

    always_ff @(posedge clk) begin
      if (rx_push) rxm_q[rxw_q[AW-1:0]] <= rx_data[c*W +: W];
      if (tx_push) txm_q[txw_q[AW-1:0]] <= cpu_wdata;
    end

    assign rx_ack[c]          = (rs_q == R_ACK);
    assign tx_req[c]          = (ts_q == T_REQ);
    assign tx_data[c*W +: W]  = txd_q;
    assign rx_avail[c]        = avail_q;
    assign tx_full[c]         = full_q;
    assign wr_drop[c]         = drop_q;
  end

  always_comb begin
    cpu_rdata_d = cpu_rdata_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (cpu_rd && (cpu_sel == SW'(i)) && rx_nonempty[i]) cpu_rdata_d = rx_head[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rdata_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      cpu_rdata_q <= cpu_rdata_d;
      irq_q       <= |(rx_avail & irq_en);
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign irq       = irq_q;
endmodule

// File: tb/tb_cpu_io_hub.sv
// Self-checking bench for cpu_io_hub: directed scenarios plus a randomized run
// checked against queue-based FIFO models and a tx launch monitor.
module tb_cpu_io_hub;
  localparam int NCH = 2, DEPTH = 4, W = 8, SW = 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NCH-1:0]   rx_irr = '0;
  logic [NCH*W-1:0] rx_data = '0;
  logic [NCH-1:0]   rx_ack, tx_req, rx_avail, tx_full, wr_drop;
  logic [NCH*W-1:0] tx_data;
  logic [NCH-1:0]   tx_busy;
  logic [SW-1:0]    cpu_sel = '0;
  logic             cpu_rd = 1'b0, cpu_wr = 1'b0, clr_drop = 1'b0;
  logic [W-1:0]     cpu_rdata, cpu_wdata = '0;
  logic [NCH-1:0]   irq_en = '0;
  logic             irq;

  cpu_io_hub #(.NCH(NCH), .DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .reset(reset), .rx_irr(rx_irr), .rx_data(rx_data), .rx_ack(rx_ack),
    .tx_req(tx_req), .tx_data(tx_data), .tx_busy(tx_busy), .cpu_sel(cpu_sel),
    .cpu_rd(cpu_rd), .cpu_rdata(cpu_rdata), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .rx_avail(rx_avail), .tx_full(tx_full), .irq_en(irq_en), .irq(irq),
    .wr_drop(wr_drop), .clr_drop(clr_drop)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [W-1:0] mrx    [NCH][$];
  logic [W-1:0] obs_q  [NCH][$];
  logic [W-1:0] exp_tx [NCH][$];
  logic [W-1:0] last_rdata = '0;
  logic [NCH-1:0] tx_hold = '0, busy_auto = '0, prev_req = '0;
  int busy_cnt [NCH] = '{default: 0};

  always_comb begin
    for (int c = 0; c < NCH; c++) tx_busy[c] = tx_hold[c] || (busy_cnt[c] != 0);
  end

  // Peripheral model: records launches, checks strobe width, drives busy for 3 cycles.
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (tx_req[c]) begin
        checks++;
        if (tx_busy[c] || prev_req[c]) begin
          errors++;
          $display("FAIL tx_req_legal ch%0d: busy=%b prev_req=%b, required busy=0 prev_req=0",
                   c, tx_busy[c], prev_req[c]);
        end
        obs_q[c].push_back(tx_data[c*W +: W]);
        if (busy_auto[c]) busy_cnt[c] = 3;
      end else if (busy_cnt[c] > 0) begin
        busy_cnt[c]--;
      end
      prev_req[c] = tx_req[c];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_models();
    for (int c = 0; c < NCH; c++) begin
      mrx[c].delete();
      obs_q[c].delete();
      exp_tx[c].delete();
    end
    last_rdata = '0;
  endtask

  task automatic wait_ack(input int c, input logic lvl, input string nm);
    int n = 0;
    step();
    while (rx_ack[c] !== lvl && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (rx_ack[c] !== lvl) begin
      errors++;
      $display("FAIL %s ch%0d: rx_ack=%b required %b (timeout)", nm, c, rx_ack[c], lvl);
    end
  endtask

  task automatic rx_send(input int c, input logic [W-1:0] b);
    rx_data[c*W +: W] = b;
    rx_irr[c] = 1'b1;
    wait_ack(c, 1'b1, "rx_ack_rise");
    mrx[c].push_back(b);
    rx_irr[c] = 1'b0;
    wait_ack(c, 1'b0, "rx_ack_fall");
    checks++;
    if (rx_avail[c] !== 1'b1) begin
      errors++;
      $display("FAIL rx_avail_after_send ch%0d: got %b required 1", c, rx_avail[c]);
    end
  endtask

  task automatic cpu_read(input int c, input string nm);
    logic [W-1:0] exp;
    cpu_sel = SW'(c);
    cpu_rd = 1'b1;
    step();
    cpu_rd = 1'b0;
    if (mrx[c].size() > 0) begin
      exp = mrx[c].pop_front();
      last_rdata = exp;
    end else begin
      exp = last_rdata;
    end
    checks++;
    if (cpu_rdata !== exp) begin
      errors++;
      $display("FAIL %s ch%0d: cpu_rdata=%h required %h", nm, c, cpu_rdata, exp);
    end
    checks++;
    if (rx_avail[c] !== (mrx[c].size() != 0)) begin
      errors++;
      $display("FAIL %s_avail ch%0d: rx_avail=%b required %b", nm, c, rx_avail[c], mrx[c].size() != 0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({rx_ack, tx_req, tx_data, cpu_rdata, rx_avail, tx_full, irq, wr_drop} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b req=%b txd=%h rd=%h av=%b full=%b irq=%b drop=%b required all 0",
               rx_ack, tx_req, tx_data, cpu_rdata, rx_avail, tx_full, irq, wr_drop);
    end
    reset = 1'b0;
    clear_models();
  endtask

  task automatic test_rx_basic();
    rx_data[0 +: W] = 8'h41;
    rx_irr[0] = 1'b1;
    step();
    checks++;
    if (rx_ack[0] !== 1'b1 || rx_avail[0] !== 1'b1) begin
      errors++;
      $display("FAIL rx_basic_capture: ack=%b avail=%b required 1 1", rx_ack[0], rx_avail[0]);
    end
    mrx[0].push_back(8'h41);
    rx_irr[0] = 1'b0;
    step();
    checks++;
    if (rx_ack[0] !== 1'b0) begin
      errors++;
      $display("FAIL rx_basic_release: ack=%b required 0", rx_ack[0]);
    end
    cpu_read(0, "rx_basic_read");
  endtask

  task automatic test_rx_backpressure();
    for (int i = 0; i < DEPTH; i++) rx_send(1, 8'h10 + 8'(i));
    rx_data[W +: W] = 8'h14;
    rx_irr[1] = 1'b1;
    repeat (3) step();
    checks++;
    if (rx_ack[1] !== 1'b0) begin
      errors++;
      $display("FAIL rx_full_backpressure: ack=%b required 0", rx_ack[1]);
    end
    cpu_read(1, "rx_full_first_read");
    wait_ack(1, 1'b1, "rx_full_recapture");
    mrx[1].push_back(8'h14);
    rx_irr[1] = 1'b0;
    wait_ack(1, 1'b0, "rx_full_release");
    for (int i = 0; i < DEPTH; i++) cpu_read(1, "rx_full_drain");
  endtask

  task automatic test_tx_busy();
    int n = 0;
    clear_models();
    busy_auto[0] = 1'b1;
    cpu_sel = 1'b0;
    cpu_wdata = 8'hA5;
    cpu_wr = 1'b1;
    step();
    cpu_wdata = 8'h5A;
    step();
    cpu_wr = 1'b0;
    checks++;
    if (tx_req[0] !== 1'b1 || tx_data[0 +: W] !== 8'hA5) begin
      errors++;
      $display("FAIL tx_latency: req=%b data=%h required 1 a5", tx_req[0], tx_data[0 +: W]);
    end
    while (obs_q[0].size() < 2 && n < 40) begin
      step();
      n++;
    end
    repeat (6) step();
    checks++;
    if (obs_q[0].size() != 2 || obs_q[0][0] !== 8'hA5 || obs_q[0][1] !== 8'h5A) begin
      errors++;
      $display("FAIL tx_busy_sequence: launches=%0d first=%h second=%h required 2 a5 5a",
               obs_q[0].size(), obs_q[0].size() > 0 ? obs_q[0][0] : 8'h00,
               obs_q[0].size() > 1 ? obs_q[0][1] : 8'h00);
    end
    busy_auto[0] = 1'b0;
  endtask

  task automatic test_tx_full_drop();
    int n = 0;
    clear_models();
    tx_hold[1] = 1'b1;
    cpu_sel = 1'b1;
    cpu_wr = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      cpu_wdata = 8'h30 + 8'(i);
      step();
      if (i == DEPTH - 1) begin
        checks++;
        if (tx_full[1] !== 1'b1 || wr_drop[1] !== 1'b0) begin
          errors++;
          $display("FAIL tx_fill: full=%b drop=%b required 1 0", tx_full[1], wr_drop[1]);
        end
      end
    end
    cpu_wr = 1'b0;
    checks++;
    if (wr_drop[1] !== 1'b1 || wr_drop[0] !== 1'b0) begin
      errors++;
      $display("FAIL wr_drop_set: drop=%b required 10", wr_drop);
    end
    clr_drop = 1'b1;
    step();
    checks++;
    if (wr_drop !== 2'b00) begin
      errors++;
      $display("FAIL wr_drop_clear: drop=%b required 00", wr_drop);
    end
    cpu_wr = 1'b1;
    step();
    checks++;
    if (wr_drop[1] !== 1'b1) begin
      errors++;
      $display("FAIL wr_drop_vs_clear: drop=%b required 1", wr_drop[1]);
    end
    cpu_wr = 1'b0;
    step();
    clr_drop = 1'b0;
    tx_hold[1] = 1'b0;
    while (obs_q[1].size() < DEPTH && n < 60) begin
      step();
      n++;
    end
    repeat (4) step();
    checks++;
    if (obs_q[1].size() != DEPTH || tx_full[1] !== 1'b0) begin
      errors++;
      $display("FAIL tx_drain: launches=%0d full=%b required %0d 0", obs_q[1].size(), tx_full[1], DEPTH);
    end
    for (int i = 0; i < obs_q[1].size() && i < DEPTH; i++) begin
      checks++;
      if (obs_q[1][i] !== 8'h30 + 8'(i)) begin
        errors++;
        $display("FAIL tx_drain_order[%0d]: data=%h required %h", i, obs_q[1][i], 8'h30 + 8'(i));
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [W-1:0] exp;
    rx_send(0, 8'h50);
    rx_send(0, 8'h51);
    rx_data[0 +: W] = 8'h52;
    rx_irr[0] = 1'b1;
    cpu_sel = 1'b0;
    cpu_rd = 1'b1;
    step();
    cpu_rd = 1'b0;
    exp = mrx[0].pop_front();
    last_rdata = exp;
    mrx[0].push_back(8'h52);
    checks++;
    if (rx_ack[0] !== 1'b1 || cpu_rdata !== exp) begin
      errors++;
      $display("FAIL same_cycle_push_pop: ack=%b rdata=%h required 1 %h", rx_ack[0], cpu_rdata, exp);
    end
    rx_irr[0] = 1'b0;
    wait_ack(0, 1'b0, "same_cycle_release");
    cpu_read(0, "same_cycle_drain");
    cpu_read(0, "same_cycle_drain");
    cpu_read(0, "read_empty_holds");
  endtask

  task automatic test_irq();
    irq_en = 2'b01;
    rx_send(1, 8'h77);
    step();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_masked: irq=%b required 0", irq);
    end
    irq_en = 2'b10;
    step();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_enabled: irq=%b required 1", irq);
    end
    irq_en = 2'b00;
    cpu_read(1, "irq_drain");
  endtask

  task automatic test_reset_mid();
    rx_data[0 +: W] = 8'h99;
    rx_irr[0] = 1'b1;
    step();
    reset = 1'b1;
    step();
    checks++;
    if (rx_ack[0] !== 1'b0 || rx_avail !== 2'b00 || cpu_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_drop: ack=%b avail=%b rdata=%h required 0 00 00", rx_ack[0], rx_avail, cpu_rdata);
    end
    reset = 1'b0;
    clear_models();
    step();
    checks++;
    if (rx_ack[0] !== 1'b1 || rx_avail[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_recapture: ack=%b avail=%b required 1 1", rx_ack[0], rx_avail[0]);
    end
    mrx[0].push_back(8'h99);
    rx_irr[0] = 1'b0;
    wait_ack(0, 1'b0, "reset_mid_release");
    cpu_read(0, "reset_mid_read");
  endtask

  task automatic test_random();
    int n = 0;
    for (int c = 0; c < NCH; c++) begin
      obs_q[c].delete();
      exp_tx[c].delete();
    end
    for (int it = 0; it < 80; it++) begin
      int c = $urandom_range(0, NCH - 1);
      int op = $urandom_range(0, 2);
      logic [W-1:0] b = W'($urandom);
      if (op == 0 && mrx[c].size() < DEPTH) begin
        rx_send(c, b);
      end else if (op == 2) begin
        cpu_sel = SW'(c);
        cpu_wdata = b;
        cpu_wr = 1'b1;
        step();
        cpu_wr = 1'b0;
        exp_tx[c].push_back(b);
        repeat (5) step();
      end else begin
        cpu_read(c, "rand_read");
      end
    end
    while ((obs_q[0].size() < exp_tx[0].size() || obs_q[1].size() < exp_tx[1].size()) && n < 40) begin
      step();
      n++;
    end
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (obs_q[c] != exp_tx[c]) begin
        errors++;
        $display("FAIL rand_tx_stream ch%0d: launched %0d bytes required %0d matching bytes",
                 c, obs_q[c].size(), exp_tx[c].size());
      end
      while (mrx[c].size() > 0) cpu_read(c, "rand_final_drain");
    end
  endtask

  initial begin
    test_reset();
    test_rx_basic();
    test_rx_backpressure();
    test_tx_busy();
    test_tx_full_drop();
    test_same_cycle();
    test_irq();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cpu_io_hub.md
# cpu_io_hub

Parametrised multi-channel I/O hub between the CPU core and its serial peripherals. It generalises the core's single rx (irr/ack) and tx (req/busy) handshake to NCH independent channels. Each channel has a DEPTH-entry receive FIFO and a DEPTH-entry transmit FIFO, so the core reads and writes bytes without stalling on peripheral timing. Instantiated beside the core, with one UART receiver/transmitter pair per channel.

## Interface
- NCH, 2, number of channels (1..8)
- DEPTH, 4, entries per FIFO, power of two, ≥2
- W, 8, data width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- rx_irr  in  NCH  per-channel receive request, held with data until acknowledged
- rx_data  in  NCH*W  per-channel receive data, channel c at [c*W +: W]
- rx_ack  out  NCH  per-channel receive acknowledge
- tx_req  out  NCH  per-channel one-cycle transmit strobe
- tx_data  out  NCH*W  per-channel transmit data, stable from tx_req until next launch
- tx_busy  in  NCH  per-channel transmitter busy
- cpu_sel  in  max(1,$clog2(NCH))  channel addressed by cpu_rd/cpu_wr
- cpu_rd  in  1  pop rx FIFO of cpu_sel
- cpu_rdata  out  W  popped byte, registered
- cpu_wr  in  1  push cpu_wdata to tx FIFO of cpu_sel
- cpu_wdata  in  W  byte to transmit
- rx_avail  out  NCH  rx FIFO non-empty, per channel
- tx_full  out  NCH  tx FIFO full, per channel
- irq_en  in  NCH  interrupt enable mask
- irq  out  1  OR over (rx_avail & irq_en), registered
- wr_drop  out  NCH  sticky: cpu_wr to a full tx FIFO
- clr_drop  in  1  clears all wr_drop bits

## Operation
- RX handshake per channel (4-phase), FSM R_IDLE/R_ACK:
  - R_IDLE: if rx_irr=1 and FIFO not full, push rx_data, go to R_ACK (rx_ack=1 from next cycle).
  - R_IDLE with FIFO full: no push, rx_ack stays 0; the peripheral holds irr (backpressure, no loss).
  - R_ACK: rx_ack=1; when rx_irr=0, go to R_IDLE (rx_ack=0 next cycle).
- TX launch per channel, FSM T_IDLE/T_REQ/T_GUARD/T_WAIT:
  - T_IDLE: if FIFO non-empty and tx_busy=0, pop head into tx_data register, go to T_REQ.
  - T_REQ: tx_req=1 for exactly this cycle, then T_GUARD.
  - T_GUARD: one cycle, tx_busy ignored (covers the peripheral's busy-rise latency), then T_WAIT.
  - T_WAIT: when tx_busy=0, go to T_IDLE.
- CPU read: cpu_rd pops the selected rx FIFO; cpu_rdata updates the next cycle. cpu_rd on an empty FIFO is ignored and cpu_rdata holds its value.
- CPU write: cpu_wr pushes to the selected tx FIFO if not full; otherwise no push and wr_drop[sel] sets.
- clr_drop clears wr_drop. A simultaneous drop event wins (bit stays 1).
- Same-cycle push and pop on one FIFO: both occur, count unchanged. Pop on full or push on empty is legal.
- FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full = MSBs differ and LSBs equal.
- Channels are fully independent. There is no arbitration.

## Timing
- Reset values: rx_ack=0, tx_req=0, tx_data=0, cpu_rdata=0, rx_avail=0, tx_full=0, irq=0, wr_drop=0. All FIFOs are empty and all FSMs are idle.
- Reset mid-handshake: rx_ack drops and a held rx_irr is recaptured after reset; this is the defined behaviour. Reset during T_REQ/T_WAIT abandons the transfer.
- rx_irr rise to rx_ack rise: 1 cycle, when not full.
- rx_avail rises 1 cycle after push. irq follows rx_avail/irq_en by 1 further cycle.
- cpu_wr to tx_req: minimum 2 cycles (push, then T_IDLE pop, then T_REQ).
- Back-to-back launches on one channel: minimum 4 cycles apart with tx_busy tied 0.
- rx_avail, tx_full and wr_drop are registered outputs reflecting post-update state.

## Test plan
- Reset, then NCH=2: all outputs 0; rx_irr[0]=1 with data 0x41 → rx_ack[0]=1 next cycle, rx_avail[0]=1; drop irr → ack 0 next cycle; cpu_sel=0, cpu_rd → cpu_rdata=0x41, rx_avail[0]=0.
- Fill rx FIFO of ch1 with DEPTH=4 bytes 0x10..0x13; 5th irr held → rx_ack[1] stays 0 until one cpu_rd, then captures 0x14. Read order is 0x11,0x12,0x13,0x14 after the first read of 0x10.
- cpu_wr 0xA5 then 0x5A on ch0 with tx_busy modelled high for 3 cycles after each tx_req → two single-cycle tx_req pulses with tx_data 0xA5 then 0x5A, and no second req while busy=1.
- 5 cpu_wr on ch1 with tx_busy=1 held → tx_full[1]=1, wr_drop[1]=1 after the 5th; clr_drop → 0.
- Same-cycle rx capture and cpu_rd on ch0 with 2 entries → count stays 2. irq_en=0b01 with data only on ch1 → irq=0; irq_en=0b10 → irq=1 one cycle later.
- Assert reset while rx_ack[0]=1 and rx_irr[0] held → ack drops, byte recaptured, rx_avail[0]=1 after reset.
